// File: rtl/addsub_result_display_pkg.sv
// Shared types and constants for the add/sub result display stage.
// FSM encodings, segment patterns and digit-mux codes.
package addsub_result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // Active-low patterns, bit 0 = segment a, bit 6 = segment g
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Codes 0-9 are the decimal digits themselves
    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_DASH  = 4'hB;
    localparam logic [3:0] CODE_E     = 4'hC;

endpackage

// File: rtl/addsub_result_display_if.sv
// Operand/result capture inputs and display outputs of the result stage.
// master = producer/board side, slave = display stage.
interface addsub_result_display_if;

    logic       load;
    logic       signed_mode;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       as;
    logic [3:0] s;
    logic       cout;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       valid;

    modport master (
        output load, signed_mode, op_a, op_b, as, s, cout,
        input  seg, an, dp, valid
    );

    modport slave (
        input  load, signed_mode, op_a, op_b, as, s, cout,
        output seg, an, dp, valid
    );

endinterface

// File: rtl/addsub_result_display_seg7_decoder.sv
// Combinational digit-code to active-low seven-segment decoder.
// Codes 0-9 are digits; blank/dash/E use reserved codes.
module seg7_decoder
    import addsub_result_display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:      seg_o = SEG_0;
            4'd1:      seg_o = SEG_1;
            4'd2:      seg_o = SEG_2;
            4'd3:      seg_o = SEG_3;
            4'd4:      seg_o = SEG_4;
            4'd5:      seg_o = SEG_5;
            4'd6:      seg_o = SEG_6;
            4'd7:      seg_o = SEG_7;
            4'd8:      seg_o = SEG_8;
            4'd9:      seg_o = SEG_9;
            CODE_DASH: seg_o = SEG_DASH;
            CODE_E:    seg_o = SEG_E;
            default:   seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/addsub_result_display.sv
// Adder/subtractor result capture, BCD conversion and 4-digit scan.
// Optional BLINK_OVF_EN blanks the display periodically on overflow.
module addsub_result_display
    import addsub_result_display_pkg::*;
#(
    parameter int CNT_W = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    addsub_result_display_if.slave   bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               mode_q, mode_d;
    logic [4:0]         mag_q, mag_d;
    logic [1:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;

    logic               cap_neg;
    logic               cap_ovf;
    logic [4:0]         cap_mag;
    logic [4:0]         rem_w;
    logic [1:0]         idx_w;
    logic [3:0]         code_w;
    logic [3:0]         an_w;
    logic               valid_w;
    logic               unused_w;

    assign unused_w = ^{bus.op_a[2:0], bus.op_b[2:0]};

    always_comb begin
        cap_neg = 1'b0;
        cap_ovf = 1'b0;
        cap_mag = {bus.cout, bus.s};
        if (bus.signed_mode) begin
            cap_neg = bus.s[3];
            cap_mag = bus.s[3] ? 5'd16 - {1'b0, bus.s}
                               : {1'b0, bus.s};
            cap_ovf = (bus.op_a[3] == (bus.op_b[3] ^ bus.as))
                   && (bus.s[3] != bus.op_a[3]);
        end else if (bus.as) begin
            cap_neg = ~bus.cout;
            cap_mag = bus.cout ? {1'b0, bus.s}
                               : 5'd16 - {1'b0, bus.s};
        end
    end

    // Remaining work = mag - 10*tens, so no separate work register
    assign rem_w = mag_q - ({tens_q, 3'b000} + {2'b00, tens_q, 1'b0});

    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        mag_d   = mag_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        unique case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (bus.load) begin
                    neg_d   = cap_neg;
                    ovf_d   = cap_ovf;
                    mode_d  = bus.signed_mode;
                    mag_d   = cap_mag;
                    tens_d  = 2'd0;
                    ones_d  = 4'd0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (rem_w >= 5'd10) begin
                    tens_d = tens_q + 2'd1;
                end else begin
                    ones_d  = rem_w[3:0];
                    state_d = ST_SHOW;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            mode_q  <= 1'b0;
            mag_q   <= 5'd0;
            tens_q  <= 2'd0;
            ones_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
            mag_q   <= mag_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign valid_w = (state_q == ST_SHOW);
    assign idx_w   = cnt_q[CNT_W-1:CNT_W-2];

    always_comb begin
        code_w = CODE_DASH;
        if (valid_w) begin
            unique case (idx_w)
                2'd3: code_w = neg_q ? CODE_DASH : CODE_BLANK;
                2'd2: code_w = (ovf_q && mode_q) ? CODE_E : CODE_BLANK;
                2'd1: code_w = (tens_q == 2'd0) ? CODE_BLANK
                                                : {2'b00, tens_q};
                default: code_w = ones_q;
            endcase
        end
    end

`ifdef BLINK_OVF_EN
    logic [3:0] blink_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 4'd0;
        end else if (&cnt_q) begin
            blink_q <= blink_q + 4'd1;
        end
    end

    always_comb begin
        an_w = ~(4'b0001 << idx_w);
        if (valid_w && ovf_q && blink_q[3]) begin
            an_w = 4'b1111;
        end
    end
`else
    assign an_w = ~(4'b0001 << idx_w);
`endif

    seg7_decoder u_dec (
        .code_i (code_w),
        .seg_o  (bus.seg)
    );

    assign bus.an    = an_w;
    assign bus.dp    = 1'b1;
    assign bus.valid = valid_w;

endmodule

// File: tb/tb_addsub_result_display.sv
// Directed-vector bench for addsub_result_display with CNT_W=4.
// Each task drives one scenario and checks its own results.
module tb_addsub_result_display;

    localparam int CNT_W = 4;

    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [6:0] S_DA = 7'b0111111;
    localparam logic [6:0] S_E  = 7'b0000110;
    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_1  = 7'b1111001;
    localparam logic [6:0] S_2  = 7'b0100100;
    localparam logic [6:0] S_3  = 7'b0110000;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_8  = 7'b0000000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    addsub_result_display_if bus();

    addsub_result_display #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic drive(input logic sm, input logic [3:0] a,
                         input logic [3:0] b, input logic as_v,
                         input logic [3:0] s_v, input logic c_v);
        bus.signed_mode = sm;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.as          = as_v;
        bus.s           = s_v;
        bus.cout        = c_v;
    endtask

    // Returns 1 ns after edge E0 (the capturing edge)
    task automatic fire_load();
        @(posedge clk);
        #1 bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic grab(output logic [6:0] d3, output logic [6:0] d2,
                        output logic [6:0] d1, output logic [6:0] d0,
                        output bit to);
        logic [6:0] d [4];
        to = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] want;
            int n;
            want = ~(4'b0001 << k);
            n = 0;
            while (bus.an !== want && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 40) to = 1'b1;
            d[k] = bus.seg;
        end
        d3 = d[3];
        d2 = d[2];
        d1 = d[1];
        d0 = d[0];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.load = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b want=0", bus.valid);
        end
        checks++;
        if (bus.an !== 4'b1110) begin
            errors++;
            $display("FAIL reset_an got=%b want=1110", bus.an);
        end
        checks++;
        if (bus.seg !== S_DA) begin
            errors++;
            $display("FAIL reset_seg got=%b want=%b", bus.seg, S_DA);
        end
        checks++;
        if (bus.dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_dp got=%b want=1", bus.dp);
        end
        rst = 1'b0;
    endtask

    task automatic test_signed_ovf();
        int lat;
        bit to;
        logic [6:0] d3, d2, d1, d0;
        drive(1'b1, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0);
        fire_load();
        wait_valid(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL sovf_latency got=%0d want=1", lat);
        end
        grab(d3, d2, d1, d0, to);
        checks++;
        if (to || d3 !== S_DA || d2 !== S_E
            || d1 !== S_BL || d0 !== S_8) begin
            errors++;
            $display("FAIL sovf_digits got=%b %b %b %b to=%b",
                     d3, d2, d1, d0, to);
        end
    endtask

    task automatic test_unsigned_max();
        int lat;
        bit to;
        logic [6:0] d3, d2, d1, d0;
        drive(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1);
        fire_load();
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL umax_valid_drop got=%b want=0", bus.valid);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL umax_latency got=%0d want=4", lat);
        end
        grab(d3, d2, d1, d0, to);
        checks++;
        if (to || d3 !== S_BL || d2 !== S_BL
            || d1 !== S_3 || d0 !== S_0) begin
            errors++;
            $display("FAIL umax_digits got=%b %b %b %b to=%b",
                     d3, d2, d1, d0, to);
        end
    endtask

    task automatic test_unsigned_borrow();
        int lat;
        bit to;
        logic [6:0] d3, d2, d1, d0;
        drive(1'b0, 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0);
        fire_load();
        wait_valid(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL ubor_latency got=%0d want=1", lat);
        end
        grab(d3, d2, d1, d0, to);
        checks++;
        if (to || d3 !== S_DA || d2 !== S_BL
            || d1 !== S_BL || d0 !== S_2) begin
            errors++;
            $display("FAIL ubor_digits got=%b %b %b %b to=%b",
                     d3, d2, d1, d0, to);
        end
    endtask

    task automatic test_signed_sub();
        int lat;
        bit to;
        logic [6:0] d3, d2, d1, d0;
        drive(1'b1, 4'b1101, 4'b0010, 1'b1, 4'b1011, 1'b1);
        fire_load();
        wait_valid(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL ssub_latency got=%0d want=1", lat);
        end
        grab(d3, d2, d1, d0, to);
        checks++;
        if (to || d3 !== S_DA || d2 !== S_BL
            || d1 !== S_BL || d0 !== S_5) begin
            errors++;
            $display("FAIL ssub_digits got=%b %b %b %b to=%b",
                     d3, d2, d1, d0, to);
        end
    endtask

    task automatic test_load_in_conv();
        int lat;
        bit to;
        logic [6:0] d3, d2, d1, d0;
        drive(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1111, 1'b1);
        fire_load();
        // Second load lands on edge E0+1 while converting
        drive(1'b0, 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0);
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
        wait_valid(lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL conv_ign_latency got=%0d want=3", lat);
        end
        grab(d3, d2, d1, d0, to);
        checks++;
        if (to || d3 !== S_BL || d2 !== S_BL
            || d1 !== S_3 || d0 !== S_1) begin
            errors++;
            $display("FAIL conv_ign_digits got=%b %b %b %b to=%b",
                     d3, d2, d1, d0, to);
        end
        fire_load();
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL show_reload_drop got=%b want=0", bus.valid);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL show_reload_latency got=%0d want=1", lat);
        end
        grab(d3, d2, d1, d0, to);
        checks++;
        if (to || d3 !== S_DA || d2 !== S_BL
            || d1 !== S_BL || d0 !== S_2) begin
            errors++;
            $display("FAIL show_reload_digits got=%b %b %b %b to=%b",
                     d3, d2, d1, d0, to);
        end
    endtask

    task automatic test_rst_wins();
        @(posedge clk);
        #1;
        drive(1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0);
        rst = 1'b1;
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.load = 1'b0;
        checks++;
        if (bus.valid !== 1'b0 || bus.an !== 4'b1110) begin
            errors++;
            $display("FAIL rst_wins_now valid=%b an=%b want 0/1110",
                     bus.valid, bus.an);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.valid !== 1'b0 || bus.seg !== S_DA) begin
            errors++;
            $display("FAIL rst_wins_later valid=%b seg=%b want 0/%b",
                     bus.valid, bus.seg, S_DA);
        end
    endtask

    task automatic test_reset_mid_conv();
        drive(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1);
        fire_load();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid got=%b want=0", bus.valid);
        end
        checks++;
        if (bus.an !== 4'b1110) begin
            errors++;
            $display("FAIL midrst_an got=%b want=1110", bus.an);
        end
        checks++;
        if (bus.seg !== S_DA) begin
            errors++;
            $display("FAIL midrst_seg got=%b want=%b", bus.seg, S_DA);
        end
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] want;
            logic [3:0] cnt;
            cnt = 4'(i);
            want = ~(4'b0001 << cnt[3:2]);
            @(posedge clk);
            #1;
            checks++;
            if (bus.an !== want || bus.seg !== S_DA) begin
                errors++;
                $display("FAIL scan_%0d an=%b seg=%b want %b/%b",
                         i, bus.an, bus.seg, want, S_DA);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_ovf();
        test_unsigned_max();
        test_unsigned_borrow();
        test_signed_sub();
        test_load_in_conv();
        test_rst_wins();
        test_reset_mid_conv();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_result_display.md
Name: addsub_result_display

Overview:
- Downstream stage of the 4-bit adder/subtractor.
- Captures the operands, mode and result {cout, s} on a load pulse, then derives sign, magnitude and signed overflow.
- Converts the magnitude to two BCD digits with a multi-cycle repeated-subtraction FSM.
- Drives a 4-digit multiplexed, active-low seven-segment display (Basys3-style).

Parameters:
- CNT_W, 18, width of the free-running refresh counter. Digit select = cnt[CNT_W-1:CNT_W-2]. Benches set 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle capture strobe (already debounced/one-shot)
- signed_mode  in  1  1 = two's-complement interpretation, 0 = unsigned
- op_a  in  4  operand a fed to the adder
- op_b  in  4  operand b fed to the adder (before inversion)
- as  in  1  0 = add, 1 = subtract
- s  in  4  adder sum
- cout  in  1  adder carry out
- seg  out  7  segments, active-low, seg[0]=a … seg[6]=g
- an  out  4  digit anodes, active-low, an[0] = rightmost
- dp  out  1  decimal point, constant 1 (off)
- valid  out  1  high while a converted result is displayed

Behaviour:
- States: IDLE, CONV, SHOW.
- Reset: state=IDLE, cnt=0, all result registers 0, valid=0, an=4'b1110, seg=7'b0111111 (dash), dp=1.
  - Reset mid-CONV or mid-SHOW aborts to the same values.
- Capture: load sampled high at edge E0 in IDLE or SHOW registers neg, ovf, mag and signed_mode; state→CONV; valid→0.
  - load in CONV is ignored.
- Signed mode (signed_mode=1):
  - neg = s[3]
  - mag = neg ? (16 - s) : s, 5 bits; s=1000 gives 8
  - ovf = (op_a[3] == (op_b[3]^as)) && (s[3] != op_a[3])
- Unsigned add (signed_mode=0, as=0): neg=0, mag={cout,s} (0..31), ovf=0.
- Unsigned subtract (signed_mode=0, as=1):
  - neg = ~cout (borrow)
  - mag = cout ? s : 16 - s
  - ovf = 0
- CONV: work=mag, tens=0 on entry. Each edge:
  - if work ≥ 10: work -= 10, tens += 1
  - else: ones = work, state→SHOW, valid→1
  - valid rises at edge E0 + 1 + floor(mag/10); worst case mag=31 → E0+4.
- Scan:
  - cnt increments every clk and wraps freely.
  - idx = cnt[CNT_W-1:CNT_W-2]; an = ~(1<<idx).
  - One digit is active per idx; no ghosting state is kept.
- Digit content when valid=1:
  - an[3]: '-' if neg, else blank
  - an[2]: 'E' if ovf, else blank
  - an[1]: tens, blank if tens==0 (leading-zero suppression)
  - an[0]: ones, always shown (including 0)
- Digit content when valid=0 (IDLE, CONV): every digit shows dash.
- Simultaneous load and rst: rst wins.

Optional Feature:
- Macro: BLINK_OVF_EN.
- Defined: a 4-bit blink counter increments on every cnt wrap to 0. While state=SHOW, ovf=1 and blink[3]=1, an=4'b1111 (all dark); otherwise normal scan. Reset clears the blink counter.
- Undefined: no blink counter; the overflow display is steady.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE, ST_CONV, ST_SHOW
  - segment constants SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111, SEG_E=7'b0000110
  - digit codes for 0–9
- One natural sub-module: seg7_decoder. It maps a 4-bit code (0–9, plus reserved codes for blank/dash/E) to seg. It is purely combinational and is instantiated once after the digit mux.

Test Plan (CNT_W=4):
- Signed overflow: signed_mode=1, op_a=0111, op_b=0001, as=0, s=1000, cout=0, load → valid at E0+1; digits '-','E',blank,'8'.
- Unsigned maximum: signed_mode=0, op_a=1111, op_b=1111, as=0, s=1110, cout=1 → mag=30; valid exactly at E0+4; digits blank,blank,'3','0'.
- Unsigned borrow: signed_mode=0, op_a=0011, op_b=0101, as=1, s=1110, cout=0 → '-',blank,blank,'2'.
- Signed subtract, no overflow: op_a=1101, op_b=0010, as=1, s=1011, cout=1 → '-',blank,blank,'5'.
- load pulsed during CONV (mag=31) → ignored; result stays 31. New load in SHOW → valid drops next edge, then the new result appears.
- rst asserted mid-CONV → next edge state IDLE, valid=0, an=1110, seg=dash. Scan order checked: an cycles 1110→1101→1011→0111 every 4 clk.
